// File: rtl/uart_tx_feeder_if.sv
// -----------------------------------------------------------------------------
// uart_tx_feeder_if
//   Bundles the signals around the byte-queue feeder: the upstream push side,
//   the transmitter handshake, and the status/error flags.
//
//   master : the surroundings of the feeder (upstream byte producer plus the
//            UART transmitter's busy flag) -- drives wr_en, wr_data, flush,
//            err_clr and uart_tx_busy; observes everything else.
//   slave  : the feeder itself.
//
//   Signals
//     wr_en, wr_data   push a byte into the queue this cycle
//     flush            synchronous queue clear
//     err_clr          clears the sticky ovf / tx_err flags
//     uart_tx_busy     transmitter busy (registered inside the transmitter)
//     uart_tx_en       one-cycle send strobe to the transmitter
//     uart_tx_data     byte presented to the transmitter (held until next pop)
//     full, empty      queue occupancy decodes
//     level            bytes queued, excluding the in-flight byte
//     idle             feeder idle and queue empty
//     ovf, tx_err      sticky overflow / transmitter non-response flags
// -----------------------------------------------------------------------------
interface uart_tx_feeder_if #(
  parameter int ADDR_W = 4
) ();
  logic              wr_en;
  logic [7:0]        wr_data;
  logic              flush;
  logic              err_clr;
  logic              uart_tx_busy;
  logic              uart_tx_en;
  logic [7:0]        uart_tx_data;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   level;
  logic              idle;
  logic              ovf;
  logic              tx_err;

  modport master (
    output wr_en, wr_data, flush, err_clr, uart_tx_busy,
    input  uart_tx_en, uart_tx_data, full, empty, level, idle, ovf, tx_err
  );

  modport slave (
    input  wr_en, wr_data, flush, err_clr, uart_tx_busy,
    output uart_tx_en, uart_tx_data, full, empty, level, idle, ovf, tx_err
  );
endinterface

// File: rtl/uart_tx_feeder.sv
// -----------------------------------------------------------------------------
// uart_tx_feeder
//   Byte queue in front of a UART transmitter. Upstream pushes bytes at clock
//   rate into a circular FIFO; the feeder pops one byte at a time, strobes it
//   into the transmitter for exactly one cycle, then follows the transmitter's
//   busy flag until the frame is done before releasing the next byte.
//   Overflow (push while full) and transmitter non-response (busy never rises
//   within ACK_TIMEOUT cycles) are reported through sticky flags.
//
//   Ports
//     clk   system clock
//     rst   asynchronous, active-high reset
//     bus   uart_tx_feeder_if.slave -- push side, transmitter handshake, status
//
//   Parameters
//     FIFO_DEPTH   queue depth in bytes (power of two, >= 2)
//     ADDR_W       log2(FIFO_DEPTH)
//     ACK_TIMEOUT  cycles allowed in WAIT_BUSY for busy to rise
// -----------------------------------------------------------------------------
module uart_tx_feeder #(
  parameter int FIFO_DEPTH  = 16,
  parameter int ADDR_W      = 4,
  parameter int ACK_TIMEOUT = 4
) (
  input  logic             clk,
  input  logic             rst,
  uart_tx_feeder_if.slave  bus
);

  localparam int                CNT_W   = $clog2(ACK_TIMEOUT + 1);
  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]  ACK_L   = CNT_W'(ACK_TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT_BUSY,
    S_WAIT_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [7:0]         mem [FIFO_DEPTH];
  logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]    count_q, count_d;
  logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic               tx_en_q, tx_en_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               ovf_q, ovf_d;
  logic               tx_err_q, tx_err_d;

  logic               full;
  logic               empty;
  logic               pop;
  logic               push;
  logic               ovf_set;
  logic               ack_expired;

  assign full  = (count_q == DEPTH_L);
  assign empty = (count_q == '0);

  // The head is only handed over when the transmitter is free; busy already
  // high in IDLE (after reset or a timeout) simply holds the queue.
  assign pop = (state_q == S_IDLE) && !empty && !bus.uart_tx_busy;

  // Last allowed WAIT_BUSY cycle with busy still low.
  assign ack_expired = (state_q == S_WAIT_BUSY) && !bus.uart_tx_busy &&
                       (wait_cnt_q == ACK_L - 1'b1);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output is given a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (pop)                   state_d = S_LOAD;
      S_LOAD:                                 state_d = S_WAIT_BUSY;
      S_WAIT_BUSY: if (bus.uart_tx_busy)      state_d = S_WAIT_DONE;
                   else if (ack_expired)      state_d = S_IDLE;
      S_WAIT_DONE: if (!bus.uart_tx_busy)     state_d = S_IDLE;
      default:                                state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output / datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // When full, a push still fits if the head leaves in the same cycle.
    // flush takes priority over a same-cycle push and does not flag overflow.
    push    = bus.wr_en && !bus.flush && (!full || pop);
    ovf_set = bus.wr_en && !bus.flush && full && !pop;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (bus.flush) begin
      // Clears the queue only; an in-flight frame and the FSM are untouched.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end

    // The strobe is registered from the IDLE->LOAD decision, so it is high
    // exactly while the FSM sits in LOAD.
    tx_en_d   = pop;
    tx_data_d = pop ? mem[rd_ptr_q] : tx_data_q;

    // Counter runs only in WAIT_BUSY; entering from LOAD it starts at zero.
    wait_cnt_d = (state_q == S_WAIT_BUSY) ? wait_cnt_q + 1'b1 : '0;

    // A new error event in the same cycle as err_clr keeps the flag set.
    ovf_d    = ovf_set     || (ovf_q    && !bus.err_clr);
    tx_err_d = ack_expired || (tx_err_q && !bus.err_clr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      wait_cnt_q <= '0;
      tx_en_q    <= 1'b0;
      tx_data_q  <= 8'h00;
      ovf_q      <= 1'b0;
      tx_err_q   <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      wait_cnt_q <= wait_cnt_d;
      tx_en_q    <= tx_en_d;
      tx_data_q  <= tx_data_d;
      ovf_q      <= ovf_d;
      tx_err_q   <= tx_err_d;
    end
  end

  // NOTE: the storage array has no reset; entries are only ever read after
  // being written, and leaving it out keeps it mappable to RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= bus.wr_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: registered, except full/empty/idle which decode registers only.
  // ---------------------------------------------------------------------------
  assign bus.uart_tx_en   = tx_en_q;
  assign bus.uart_tx_data = tx_data_q;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.level        = count_q;
  assign bus.idle         = (state_q == S_IDLE) && empty;
  assign bus.ovf          = ovf_q;
  assign bus.tx_err       = tx_err_q;

endmodule

// File: tb/tb_uart_tx_feeder.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_uart_tx_feeder
//   Directed bench for uart_tx_feeder. Contains a small UART transmitter model
//   (registered busy, 8N1 serial line) and a line receiver that decodes the
//   serial output. The transmitter bit period is shortened to keep runs short.
// -----------------------------------------------------------------------------
module tb_uart_tx_feeder;

  localparam int FIFO_DEPTH  = 16;
  localparam int ADDR_W      = 4;
  localparam int ACK_TIMEOUT = 4;
  localparam int BIT_CYC     = 8;
  localparam int FRAME_CYC   = 10 * BIT_CYC;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #10 clk = ~clk;

  uart_tx_feeder_if #(.ADDR_W(ADDR_W)) bus ();

  uart_tx_feeder #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .ADDR_W     (ADDR_W),
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;

  // Transmitter model controls: stall forces busy high, dead keeps it low.
  logic stall = 1'b0;
  logic dead  = 1'b0;

  logic       model_busy = 1'b0;
  logic       tx_line    = 1'b1;
  logic [9:0] shreg      = '1;
  int         bit_cnt    = 0;
  int         cyc        = 0;

  assign bus.uart_tx_busy = stall ? 1'b1 : (dead ? 1'b0 : model_busy);

  // Transmitter: samples the strobe at a clock edge, busy registered.
  always @(posedge clk) begin
    if (!model_busy) begin
      if (bus.uart_tx_en && !dead && !stall) begin
        shreg      <= {1'b1, bus.uart_tx_data, 1'b0};
        model_busy <= 1'b1;
        tx_line    <= 1'b0;
        cyc        <= 0;
        bit_cnt    <= 0;
      end
    end else if (cyc == BIT_CYC - 1) begin
      cyc <= 0;
      if (bit_cnt == 9) begin
        model_busy <= 1'b0;
        tx_line    <= 1'b1;
      end else begin
        bit_cnt <= bit_cnt + 1;
        tx_line <= shreg[bit_cnt + 1];
      end
    end else begin
      cyc <= cyc + 1;
    end
  end

  // Strobe monitor: total pulses and pulses longer than one cycle.
  int   en_cnt  = 0;
  int   en_wide = 0;
  logic en_prev = 1'b0;
  always @(posedge clk) begin
    if (bus.uart_tx_en) begin
      en_cnt <= en_cnt + 1;
      if (en_prev) en_wide <= en_wide + 1;
    end
    en_prev <= bus.uart_tx_en;
  end

  // Line receiver: mid-bit sampling, LSB first.
  logic [7:0] rx_q [$];
  initial begin : rx_proc
    logic [7:0] b;
    forever begin
      @(negedge tx_line);
      repeat (BIT_CYC / 2) @(posedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (BIT_CYC) @(posedge clk);
        b[i] = tx_line;
      end
      rx_q.push_back(b);
      repeat (BIT_CYC) @(posedge clk);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] d);
    bus.wr_data = d;
    bus.wr_en   = 1'b1;
    tick();
    bus.wr_en   = 1'b0;
  endtask

  task automatic wait_quiet(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      tick();
      if (bus.idle && !model_busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_model_busy(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      tick();
      if (model_busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    tick();
    checks++; if (bus.uart_tx_en !== 1'b0) begin failures++; $display("FAIL reset_en got=%b exp=0", bus.uart_tx_en); end
    checks++; if (bus.uart_tx_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", bus.uart_tx_data); end
    checks++; if (bus.full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", bus.full); end
    checks++; if (bus.empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", bus.empty); end
    checks++; if (bus.level !== 5'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", bus.level); end
    checks++; if (bus.idle !== 1'b1) begin failures++; $display("FAIL reset_idle got=%b exp=1", bus.idle); end
    checks++; if (bus.ovf !== 1'b0 || bus.tx_err !== 1'b0) begin failures++; $display("FAIL reset_flags got ovf=%b tx_err=%b exp 0/0", bus.ovf, bus.tx_err); end
    rst = 1'b0;
    tick();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_single();
    int e0;
    int r0;
    bit ok;
    logic [7:0] got;
    e0 = en_cnt;
    r0 = rx_q.size();
    push_byte(8'h55);                         // edge 0
    checks++; if (bus.empty !== 1'b0 || bus.level !== 5'd1) begin failures++; $display("FAIL single_after_push got empty=%b level=%0d exp 0/1", bus.empty, bus.level); end
    checks++; if (bus.uart_tx_en !== 1'b0) begin failures++; $display("FAIL single_en_early got=%b exp=0", bus.uart_tx_en); end
    tick();                                   // edge 1
    checks++; if (bus.uart_tx_en !== 1'b1 || bus.uart_tx_data !== 8'h55) begin failures++; $display("FAIL single_strobe got en=%b data=%h exp 1/55", bus.uart_tx_en, bus.uart_tx_data); end
    checks++; if (bus.level !== 5'd0) begin failures++; $display("FAIL single_level_pop got=%0d exp=0", bus.level); end
    tick();                                   // edge 2
    checks++; if (bus.uart_tx_en !== 1'b0 || bus.uart_tx_data !== 8'h55) begin failures++; $display("FAIL single_strobe_end got en=%b data=%h exp 0/55", bus.uart_tx_en, bus.uart_tx_data); end
    wait_quiet(FRAME_CYC + 40, ok);
    checks++; if (!ok) begin failures++; $display("FAIL single_done_timeout got=not_idle exp=idle"); end
    checks++; if (en_cnt - e0 !== 1) begin failures++; $display("FAIL single_en_count got=%0d exp=1", en_cnt - e0); end
    got = (rx_q.size() > r0) ? rx_q[r0] : 8'hxx;
    checks++; if (got !== 8'h55) begin failures++; $display("FAIL single_line_decode got=%h exp=55", got); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_burst();
    int e0;
    int r0;
    int bad;
    bit ok;
    e0 = en_cnt;
    r0 = rx_q.size();
    stall = 1'b1;
    for (int i = 0; i < 16; i++) push_byte(8'(i + 1));
    checks++; if (bus.full !== 1'b1 || bus.level !== 5'd16) begin failures++; $display("FAIL burst_peak got full=%b level=%0d exp 1/16", bus.full, bus.level); end
    stall = 1'b0;
    wait_quiet(16 * (FRAME_CYC + 10) + 50, ok);
    checks++; if (!ok) begin failures++; $display("FAIL burst_done_timeout got=not_idle exp=idle"); end
    checks++; if (en_cnt - e0 !== 16) begin failures++; $display("FAIL burst_en_count got=%0d exp=16", en_cnt - e0); end
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      if (rx_q.size() <= r0 + i) bad++;
      else if (rx_q[r0 + i] !== 8'(i + 1)) bad++;
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL burst_order got=%0d_bad_bytes exp=0", bad); end
    checks++; if (bus.ovf !== 1'b0) begin failures++; $display("FAIL burst_ovf got=%b exp=0", bus.ovf); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_overflow();
    int e0;
    bit ok;
    e0 = en_cnt;
    stall = 1'b1;
    for (int i = 0; i < 17; i++) push_byte(8'h80 + 8'(i));
    checks++; if (bus.level !== 5'd16 || bus.full !== 1'b1) begin failures++; $display("FAIL ovf_level got level=%0d full=%b exp 16/1", bus.level, bus.full); end
    checks++; if (bus.ovf !== 1'b1) begin failures++; $display("FAIL ovf_set got=%b exp=1", bus.ovf); end
    bus.err_clr = 1'b1; tick(); bus.err_clr = 1'b0;
    checks++; if (bus.ovf !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%b exp=0", bus.ovf); end
    bus.err_clr = 1'b1;
    push_byte(8'hEE);
    bus.err_clr = 1'b0;
    checks++; if (bus.ovf !== 1'b1 || bus.level !== 5'd16) begin failures++; $display("FAIL ovf_clr_collision got ovf=%b level=%0d exp 1/16", bus.ovf, bus.level); end
    bus.err_clr = 1'b1; tick(); bus.err_clr = 1'b0;
    checks++; if (bus.ovf !== 1'b0) begin failures++; $display("FAIL ovf_clear2 got=%b exp=0", bus.ovf); end
    // Push into a full queue while the head leaves: accepted, no overflow.
    stall = 1'b0;
    push_byte(8'hEF);
    checks++; if (bus.level !== 5'd16 || bus.ovf !== 1'b0) begin failures++; $display("FAIL full_push_pop got level=%0d ovf=%b exp 16/0", bus.level, bus.ovf); end
    checks++; if (bus.uart_tx_en !== 1'b1 || bus.uart_tx_data !== 8'h80) begin failures++; $display("FAIL full_push_pop_head got en=%b data=%h exp 1/80", bus.uart_tx_en, bus.uart_tx_data); end
    bus.flush = 1'b1; tick(); bus.flush = 1'b0;
    checks++; if (bus.level !== 5'd0 || bus.empty !== 1'b1) begin failures++; $display("FAIL ovf_flush got level=%0d empty=%b exp 0/1", bus.level, bus.empty); end
    wait_quiet(FRAME_CYC + 40, ok);
    checks++; if (!ok || en_cnt - e0 !== 1) begin failures++; $display("FAIL ovf_drain got ok=%0d pulses=%0d exp 1/1", ok, en_cnt - e0); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_timeout();
    int e1;
    bit ok;
    dead = 1'b1;
    push_byte(8'hA5);                         // edge 0
    tick();                                   // edge 1
    checks++; if (bus.uart_tx_en !== 1'b1 || bus.uart_tx_data !== 8'hA5) begin failures++; $display("FAIL to_strobe got en=%b data=%h exp 1/a5", bus.uart_tx_en, bus.uart_tx_data); end
    tick();                                   // edge 2: enter WAIT_BUSY
    checks++; if (bus.uart_tx_en !== 1'b0) begin failures++; $display("FAIL to_strobe_width got=%b exp=0", bus.uart_tx_en); end
    repeat (ACK_TIMEOUT - 1) tick();          // edge 5
    checks++; if (bus.tx_err !== 1'b0) begin failures++; $display("FAIL to_early got=%b exp=0", bus.tx_err); end
    tick();                                   // edge 6
    checks++; if (bus.tx_err !== 1'b1) begin failures++; $display("FAIL to_flag got=%b exp=1", bus.tx_err); end
    checks++; if (bus.idle !== 1'b1 || bus.level !== 5'd0) begin failures++; $display("FAIL to_idle got idle=%b level=%0d exp 1/0", bus.idle, bus.level); end
    bus.err_clr = 1'b1; tick(); bus.err_clr = 1'b0;
    checks++; if (bus.tx_err !== 1'b0) begin failures++; $display("FAIL to_clear got=%b exp=0", bus.tx_err); end
    dead = 1'b0;
    // Busy already high in IDLE: the byte must wait in the queue.
    stall = 1'b1;
    e1 = en_cnt;
    push_byte(8'h3C);
    repeat (6) tick();
    checks++; if (en_cnt !== e1 || bus.level !== 5'd1) begin failures++; $display("FAIL busy_hold got pulses=%0d level=%0d exp 0/1", en_cnt - e1, bus.level); end
    stall = 1'b0;
    tick();
    checks++; if (bus.uart_tx_en !== 1'b1 || bus.uart_tx_data !== 8'h3C) begin failures++; $display("FAIL busy_release got en=%b data=%h exp 1/3c", bus.uart_tx_en, bus.uart_tx_data); end
    wait_quiet(FRAME_CYC + 40, ok);
    checks++; if (!ok) begin failures++; $display("FAIL busy_release_done got=not_idle exp=idle"); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_push_pop_flush();
    int e0;
    int r0;
    bit ok;
    logic [7:0] got;
    e0 = en_cnt;
    r0 = rx_q.size();
    stall = 1'b1;
    push_byte(8'h3A);
    stall = 1'b0;
    push_byte(8'hC7);                         // pop 3A and push C7 together
    checks++; if (bus.level !== 5'd1) begin failures++; $display("FAIL pp_level got=%0d exp=1", bus.level); end
    checks++; if (bus.uart_tx_en !== 1'b1 || bus.uart_tx_data !== 8'h3A) begin failures++; $display("FAIL pp_strobe got en=%b data=%h exp 1/3a", bus.uart_tx_en, bus.uart_tx_data); end
    wait_model_busy(20, ok);
    checks++; if (!ok) begin failures++; $display("FAIL pp_busy_timeout got=no_busy exp=busy"); end
    repeat (3) tick();                        // now in WAIT_DONE
    bus.flush = 1'b1; tick(); bus.flush = 1'b0;
    checks++; if (bus.level !== 5'd0 || bus.empty !== 1'b1 || bus.idle !== 1'b0) begin failures++; $display("FAIL pp_flush got level=%0d empty=%b idle=%b exp 0/1/0", bus.level, bus.empty, bus.idle); end
    wait_quiet(FRAME_CYC + 40, ok);
    repeat (5) tick();
    checks++; if (!ok || en_cnt - e0 !== 1) begin failures++; $display("FAIL pp_after_flush got ok=%0d pulses=%0d exp 1/1", ok, en_cnt - e0); end
    got = (rx_q.size() > r0) ? rx_q[r0] : 8'hxx;
    checks++; if (got !== 8'h3A || rx_q.size() !== r0 + 1) begin failures++; $display("FAIL pp_frame got=%h frames=%0d exp 3a/1", got, rx_q.size() - r0); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset_mid();
    int e0;
    int e1;
    bit ok;
    e0 = en_cnt;
    stall = 1'b1;
    for (int i = 0; i < 6; i++) push_byte(8'h61 + 8'(i));
    stall = 1'b0;
    tick();                                   // pops the first byte
    wait_model_busy(20, ok);
    repeat (3) tick();                        // WAIT_DONE, five bytes queued
    checks++; if (!ok || bus.level !== 5'd5) begin failures++; $display("FAIL rm_setup got ok=%0d level=%0d exp 1/5", ok, bus.level); end
    #3 rst = 1'b1;
    #1;
    checks++; if (bus.level !== 5'd0 || bus.empty !== 1'b1 || bus.full !== 1'b0 || bus.idle !== 1'b1) begin failures++; $display("FAIL rm_queue got level=%0d empty=%b full=%b idle=%b exp 0/1/0/1", bus.level, bus.empty, bus.full, bus.idle); end
    checks++; if (bus.uart_tx_en !== 1'b0 || bus.uart_tx_data !== 8'h00 || bus.ovf !== 1'b0 || bus.tx_err !== 1'b0) begin failures++; $display("FAIL rm_outputs got en=%b data=%h ovf=%b tx_err=%b exp 0/00/0/0", bus.uart_tx_en, bus.uart_tx_data, bus.ovf, bus.tx_err); end
    tick();
    rst = 1'b0;
    e1 = en_cnt;
    for (int i = 0; i < FRAME_CYC + 20 && model_busy; i++) tick();
    repeat (20) tick();
    checks++; if (en_cnt !== e1 || en_cnt - e0 !== 1) begin failures++; $display("FAIL rm_no_strobe got pulses_after=%0d total=%0d exp 0/1", en_cnt - e1, en_cnt - e0); end
    push_byte(8'h77);
    tick();
    checks++; if (bus.uart_tx_en !== 1'b1 || bus.uart_tx_data !== 8'h77) begin failures++; $display("FAIL rm_new_push got en=%b data=%h exp 1/77", bus.uart_tx_en, bus.uart_tx_data); end
    wait_quiet(FRAME_CYC + 40, ok);
    checks++; if (!ok) begin failures++; $display("FAIL rm_done got=not_idle exp=idle"); end
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    bus.wr_en   = 1'b0;
    bus.wr_data = 8'h00;
    bus.flush   = 1'b0;
    bus.err_clr = 1'b0;
    rst         = 1'b1;
    repeat (3) @(posedge clk);
    test_reset();
    test_single();
    test_burst();
    test_overflow();
    test_timeout();
    test_push_pop_flush();
    test_reset_mid();
    checks++; if (en_wide !== 0) begin failures++; $display("FAIL en_width got=%0d_long_pulses exp=0", en_wide); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
